// File: rtl/alu_rs.sv
// Reservation station + issue scheduler for the single-cycle ALU.
// Optional `ALU_RS_AGE_PRIO_EN selects oldest-first issue instead of lowest-index issue.
module alu_rs #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic             disp_qj_busy,
  input  logic             disp_qk_busy,
  input  logic [TAG_W-1:0] disp_dest,
  output logic             rs_full,
  input  logic             cdb_alu_done,
  input  logic [TAG_W-1:0] cdb_alu_tag,
  input  logic [XLEN-1:0]  cdb_alu_data,
  input  logic             cdb_lsb_done,
  input  logic [TAG_W-1:0] cdb_lsb_tag,
  input  logic [XLEN-1:0]  cdb_lsb_data,
  output logic             alu_ready,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic [TAG_W-1:0] alu_tag
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic             bj;
    logic             bk;
    logic [TAG_W-1:0] dest;
`ifdef ALU_RS_AGE_PRIO_EN
    logic [IDX_W-1:0] age;
`endif
  } entry_t;

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic             issue_found;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] free_idx;
  logic             disp_fire;
  logic [XLEN:0]    disp_j;
  logic [XLEN:0]    disp_k;

  // Returns {busy, value} after snooping both CDB ports; the ALU port has priority.
  function automatic logic [XLEN:0] snoop(input logic busy, input logic [TAG_W-1:0] q,
                                          input logic [XLEN-1:0] v);
    if (busy && cdb_alu_done && cdb_alu_tag == q)      snoop = {1'b0, cdb_alu_data};
    else if (busy && cdb_lsb_done && cdb_lsb_tag == q) snoop = {1'b0, cdb_lsb_data};
    else                                               snoop = {busy, v};
  endfunction

  assign rs_full   = &valid;
  assign disp_fire = disp_valid & ~rs_full;
  assign disp_j    = snoop(disp_qj_busy, disp_qj, disp_vj);
  assign disp_k    = snoop(disp_qk_busy, disp_qk, disp_vk);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
  end

`ifdef ALU_RS_AGE_PRIO_EN
  logic [IDX_W-1:0] best_age;
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    best_age    = '0;
    // Strict compare keeps the lowest index among equally old entries.
    for (int i = 0; i < DEPTH; i++)
      if (ready[i] && (!issue_found || ent[i].age > best_age)) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
        best_age    = ent[i].age;
      end
  end
`else
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
  end
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign valid[gi] = ent[gi].valid;
    assign ready[gi] = ent[gi].valid & ~ent[gi].bj & ~ent[gi].bk;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ent[gi] <= '0;
      end else if (flush) begin
        ent[gi].valid <= 1'b0;
      end else if (disp_fire && free_idx == IDX_W'(gi)) begin
        ent[gi].valid                <= 1'b1;
        ent[gi].op                   <= disp_op;
        {ent[gi].bj, ent[gi].vj}     <= disp_j;
        {ent[gi].bk, ent[gi].vk}     <= disp_k;
        ent[gi].qj                   <= disp_qj;
        ent[gi].qk                   <= disp_qk;
        ent[gi].dest                 <= disp_dest;
`ifdef ALU_RS_AGE_PRIO_EN
        ent[gi].age                  <= '0;
`endif
      end else begin
        if (issue_found && issue_idx == IDX_W'(gi)) ent[gi].valid <= 1'b0;
        {ent[gi].bj, ent[gi].vj} <= snoop(ent[gi].bj, ent[gi].qj, ent[gi].vj);
        {ent[gi].bk, ent[gi].vk} <= snoop(ent[gi].bk, ent[gi].qk, ent[gi].vk);
`ifdef ALU_RS_AGE_PRIO_EN
        // Saturate so a long-waiting entry never wraps back to "youngest".
        if (disp_fire && ent[gi].valid && ent[gi].age != '1)
          ent[gi].age <= ent[gi].age + IDX_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      alu_ready <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_tag   <= '0;
    end else if (issue_found) begin
      alu_ready <= 1'b1;
      alu_a     <= ent[issue_idx].vj;
      alu_b     <= ent[issue_idx].vk;
      alu_op    <= ent[issue_idx].op;
      alu_tag   <= ent[issue_idx].dest;
    end else begin
      alu_ready <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic against an
// array-based reference model of the reservation station.
module tb_alu_rs;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int OP_W  = 5;

  logic             clk = 1'b0;
  logic             rst, flush, disp_valid;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_vj, disp_vk;
  logic [TAG_W-1:0] disp_qj, disp_qk, disp_dest;
  logic             disp_qj_busy, disp_qk_busy;
  logic             rs_full;
  logic             cdb_alu_done, cdb_lsb_done;
  logic [TAG_W-1:0] cdb_alu_tag, cdb_lsb_tag;
  logic [XLEN-1:0]  cdb_alu_data, cdb_lsb_data;
  logic             alu_ready;
  logic [XLEN-1:0]  alu_a, alu_b;
  logic [OP_W-1:0]  alu_op;
  logic [TAG_W-1:0] alu_tag;

  alu_rs #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_qj_busy(disp_qj_busy),
    .disp_qk_busy(disp_qk_busy), .disp_dest(disp_dest), .rs_full(rs_full),
    .cdb_alu_done(cdb_alu_done), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_data(cdb_alu_data),
    .cdb_lsb_done(cdb_lsb_done), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_data(cdb_lsb_data),
    .alu_ready(alu_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_tag(alu_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per slot, age tracked as a global dispatch sequence number.
  bit               m_valid [DEPTH];
  logic [OP_W-1:0]  m_op    [DEPTH];
  logic [XLEN-1:0]  m_vj    [DEPTH];
  logic [XLEN-1:0]  m_vk    [DEPTH];
  logic [TAG_W-1:0] m_qj    [DEPTH];
  logic [TAG_W-1:0] m_qk    [DEPTH];
  bit               m_bj    [DEPTH];
  bit               m_bk    [DEPTH];
  logic [TAG_W-1:0] m_dest  [DEPTH];
  int               m_seq   [DEPTH];
  int               seq_ctr = 0;
  logic             e_ready = 1'b0;
  logic [XLEN-1:0]  e_a = '0, e_b = '0;
  logic [OP_W-1:0]  e_op = '0;
  logic [TAG_W-1:0] e_tag = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cdb_resolve(input bit busy, input logic [TAG_W-1:0] q, input logic [XLEN-1:0] v,
                             output bit nbusy, output logic [XLEN-1:0] nv);
    nbusy = busy;
    nv    = v;
    if (busy && cdb_alu_done && cdb_alu_tag == q) begin
      nbusy = 1'b0; nv = cdb_alu_data;
    end else if (busy && cdb_lsb_done && cdb_lsb_tag == q) begin
      nbusy = 1'b0; nv = cdb_lsb_data;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    e_ready = 1'b0; e_a = '0; e_b = '0; e_op = '0; e_tag = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit was_full;
    int iss;
    int slot;
    if (flush) begin
      model_clear();
      return;
    end
    was_full = model_full();
    iss = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && !m_bj[i] && !m_bk[i]) begin
`ifdef ALU_RS_AGE_PRIO_EN
        if (iss < 0 || m_seq[i] < m_seq[iss]) iss = i;
`else
        if (iss < 0) iss = i;
`endif
      end
    end
    slot = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
    if (iss >= 0) begin
      e_ready = 1'b1; e_a = m_vj[iss]; e_b = m_vk[iss]; e_op = m_op[iss]; e_tag = m_dest[iss];
      m_valid[iss] = 1'b0;
    end else begin
      e_ready = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i]) begin
        cdb_resolve(m_bj[i], m_qj[i], m_vj[i], m_bj[i], m_vj[i]);
        cdb_resolve(m_bk[i], m_qk[i], m_vk[i], m_bk[i], m_vk[i]);
      end
    end
    if (disp_valid && !was_full && slot >= 0) begin
      m_valid[slot] = 1'b1;
      m_op[slot]    = disp_op;
      m_qj[slot]    = disp_qj;
      m_qk[slot]    = disp_qk;
      m_dest[slot]  = disp_dest;
      m_seq[slot]   = seq_ctr++;
      cdb_resolve(disp_qj_busy, disp_qj, disp_vj, m_bj[slot], m_vj[slot]);
      cdb_resolve(disp_qk_busy, disp_qk, disp_vk, m_bk[slot], m_vk[slot]);
    end
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0; flush = 1'b0; cdb_alu_done = 1'b0; cdb_lsb_done = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("alu_ready", alu_ready, e_ready);
    check("alu_a", alu_a, e_a);
    check("alu_b", alu_b, e_b);
    check("alu_op", alu_op, e_op);
    check("alu_tag", alu_tag, e_tag);
    check("rs_full", rs_full, model_full());
    if (alu_ready) $display("issue tag=%0d op=%0d a=%0h b=%0h", alu_tag, alu_op, alu_a, alu_b);
    idle_inputs();
  endtask

  task automatic disp(input int op, input int vj, input int vk, input int qj, input bit bj,
                      input int qk, input bit bk, input int dest);
    disp_valid = 1'b1; disp_op = OP_W'(op); disp_vj = XLEN'(vj); disp_vk = XLEN'(vk);
    disp_qj = TAG_W'(qj); disp_qj_busy = bj; disp_qk = TAG_W'(qk); disp_qk_busy = bk;
    disp_dest = TAG_W'(dest);
  endtask

  task automatic cdb_alu(input int tag, input int data);
    cdb_alu_done = 1'b1; cdb_alu_tag = TAG_W'(tag); cdb_alu_data = XLEN'(data);
  endtask

  task automatic cdb_lsb(input int tag, input int data);
    cdb_lsb_done = 1'b1; cdb_lsb_tag = TAG_W'(tag); cdb_lsb_data = XLEN'(data);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, alu_ready, 1'b0);
    check({tag, "_a"}, alu_a, 0);
    check({tag, "_b"}, alu_b, 0);
    check({tag, "_op"}, alu_op, 0);
    check({tag, "_tag"}, alu_tag, 0);
    check({tag, "_full"}, rs_full, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    disp_op = '0; disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
    disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_dest = '0;
    cdb_alu_tag = '0; cdb_alu_data = '0; cdb_lsb_tag = '0; cdb_lsb_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Both operands ready: issue one cycle after dispatch, then idle.
    disp(0, 5, 7, 0, 0, 0, 0, 3); tick();
    check("t1_no_early_issue", alu_ready, 1'b0);
    tick();
    check("t1_ready", alu_ready, 1'b1);
    check("t1_a", alu_a, 5);
    check("t1_b", alu_b, 7);
    check("t1_tag", alu_tag, 3);
    tick();
    check("t1_idle", alu_ready, 1'b0);

    // Wakeup from the LSB port.
    disp(1, 0, 11, 2, 1, 0, 0, 4); tick();
    tick(); tick();
    cdb_lsb(2, 20); tick();
    check("t2_wake_edge_no_issue", alu_ready, 1'b0);
    tick();
    check("t2_ready", alu_ready, 1'b1);
    check("t2_a", alu_a, 20);
    check("t2_b", alu_b, 11);

    // Dispatch-time forwarding from the ALU port.
    disp(2, 8, 0, 0, 0, 6, 1, 5);
    cdb_alu(6, 9); tick();
    tick();
    check("t3_ready", alu_ready, 1'b1);
    check("t3_b", alu_b, 9);
    check("t3_tag", alu_tag, 5);

    // Fill all entries blocked on tag 1, drop an extra dispatch, then drain.
    for (int i = 0; i < DEPTH; i++) begin
      disp(3, i, i + 100, 1, 1, 0, 0, i); tick();
    end
    check("t4_full", rs_full, 1'b1);
    disp(3, 1, 1, 0, 0, 0, 0, 15); tick();
    check("t4_drop_full", rs_full, 1'b1);
    check("t4_drop_noissue", alu_ready, 1'b0);
    cdb_alu(1, 100); tick();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("t4_drain_ready", alu_ready, 1'b1);
      check("t4_drain_tag", alu_tag, i);
      check("t4_drain_a", alu_a, 100);
      if (i == 0) check("t4_full_drop", rs_full, 1'b0);
    end
    tick();
    check("t4_empty", alu_ready, 1'b0);

    // Priority: oldest-first with the age option, lowest index otherwise.
    disp(4, 0, 1, 7, 1, 0, 0, 10); tick();
    disp(5, 0, 2, 8, 1, 0, 0, 11); tick();
    cdb_alu(7, 70); tick();
    tick();
    check("t5_first", alu_tag, 10);
    disp(6, 0, 3, 9, 1, 0, 0, 12); tick();
    cdb_alu(8, 80); cdb_lsb(9, 90); tick();
    tick();
    check("t5_pick_ready", alu_ready, 1'b1);
`ifdef ALU_RS_AGE_PRIO_EN
    check("t5_pick_tag", alu_tag, 11);
`else
    check("t5_pick_tag", alu_tag, 12);
`endif
    tick();
`ifdef ALU_RS_AGE_PRIO_EN
    check("t5_second_tag", alu_tag, 12);
`else
    check("t5_second_tag", alu_tag, 11);
`endif

    // Flush with entries valid and one issuing; stale wakeups must not issue.
    for (int i = 0; i < 4; i++) begin
      disp(7, i, i, 9, 1, 0, 0, i); tick();
    end
    cdb_alu(9, 1); tick();
    flush = 1'b1; tick();
    check("t6_flush_ready", alu_ready, 1'b0);
    check("t6_flush_full", rs_full, 1'b0);
    cdb_alu(9, 2); tick();
    tick();
    check("t6_stale", alu_ready, 1'b0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if (!model_full() && $urandom_range(0, 1) == 1)
        disp($urandom_range(0, 16), $urandom, $urandom, $urandom_range(0, 7),
             1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom_range(0, 15));
      if ($urandom_range(0, 9) < 4) cdb_alu($urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 9) < 4) cdb_lsb($urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 63) == 0) flush = 1'b1;
      tick();
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      disp(8, i + 1, i + 2, 0, 0, 0, 0, i + 1); tick();
    end
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_idle", alu_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
